// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM states and
// active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP     = 2'd0,
    ST_RUN      = 2'd1,
    ST_LAP_RUN  = 2'd2,
    ST_LAP_STOP = 2'd3
  } sw_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry d is the pattern for BCD digit d (index 0 is the LSB slice)
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Control strobes and display/status outputs of the lap stopwatch.
interface lap_stopwatch_if #(
  parameter int unsigned DIGITS = 4
);
  logic              start_stop;
  logic              lap;
  logic              clear;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              dp;
  logic              running;
  logic              lap_active;
  logic              overflow;

  modport master (
    output start_stop, lap, clear,
    input  an, seg, dp, running, lap_active, overflow
  );

  modport slave (
    input  start_stop, lap, clear,
    output an, seg, dp, running, lap_active, overflow
  );
endinterface

// File: rtl/bcd_counter_chain.sv
// Cascaded BCD digit counters; each digit only ever holds 0..9.
module bcd_counter_chain #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   tick_i,
  output logic [DIGITS-1:0][3:0] digits_o,
  output logic                   wrap_o
);

  logic [DIGITS-1:0] inc;

  // inc[k] is the tick gated by all lower digits sitting at 9
  always_comb begin
    logic carry;
    carry = tick_i;
    inc   = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      inc[k] = carry;
      carry  = carry && (digits_o[k] == 4'd9);
    end
    wrap_o = carry;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      digits_o <= '0;
    end else begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (inc[k]) begin
          digits_o[k] <= (digits_o[k] == 4'd9) ? 4'd0 : digits_o[k] + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/lap_stopwatch.sv
// Lap stopwatch: run/lap FSM, tick prescaler, lap capture and a
// multiplexed seven-segment scan driving registered outputs.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_FREQ = 100,
  parameter int unsigned SCAN_FREQ = 1000,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DP_POS    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_stop_i,
  input  logic              lap_i,
  input  logic              clear_i,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic              running_o,
  output logic              lap_active_o,
  output logic              overflow_o
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_FREQ;
  localparam int unsigned SCAN_DIV = CLK_FREQ / SCAN_FREQ;
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W    = $clog2(DIGITS);
  localparam logic [PRE_W-1:0]  PRE_LIM  = PRE_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LIM = SCAN_W'(SCAN_DIV - 1);

  if ((CLK_FREQ % TICK_FREQ) != 0 || (CLK_FREQ % SCAN_FREQ) != 0) begin : g_bad_freq
    $error("lap_stopwatch: CLK_FREQ must be a multiple of TICK_FREQ and SCAN_FREQ");
  end
  if (DIGITS < 2 || DIGITS > 8 || DP_POS >= DIGITS) begin : g_bad_digits
    $error("lap_stopwatch: DIGITS must be 2..8 and DP_POS below DIGITS");
  end

  sw_state_e                state_q, state_d;
  logic [PRE_W-1:0]         pre_q;
  logic [SCAN_W-1:0]        scan_q;
  logic [IDX_W-1:0]         idx_q;
  logic [DIGITS-1:0][3:0]   live, lap_q, disp;
  logic                     stopped, clr_valid, tick, wrap;

  assign running_o    = (state_q == ST_RUN)     || (state_q == ST_LAP_RUN);
  assign lap_active_o = (state_q == ST_LAP_RUN) || (state_q == ST_LAP_STOP);
  assign stopped      = !running_o;
  assign clr_valid    = clear_i && stopped;
  assign tick         = running_o && (pre_q == PRE_LIM);
  assign disp         = lap_active_o ? lap_q : live;

  // Only the highest-priority valid strobe acts: clear > start_stop > lap
  always_comb begin
    state_d = state_q;
    if (clr_valid) begin
      state_d = ST_STOP;
    end else if (start_stop_i) begin
      case (state_q)
        ST_STOP:     state_d = ST_RUN;
        ST_RUN:      state_d = ST_STOP;
        ST_LAP_RUN:  state_d = ST_LAP_STOP;
        ST_LAP_STOP: state_d = ST_LAP_RUN;
        default:     state_d = ST_STOP;
      endcase
    end else if (lap_i) begin
      case (state_q)
        ST_RUN:      state_d = ST_LAP_RUN;
        ST_LAP_RUN:  state_d = ST_RUN;
        ST_LAP_STOP: state_d = ST_STOP;
        default:     state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_STOP;
      pre_q      <= '0;
      lap_q      <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr_valid) begin
        pre_q      <= '0;
        lap_q      <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (running_o) pre_q <= tick ? '0 : pre_q + 1'b1;
        if (state_q == ST_RUN && state_d == ST_LAP_RUN) lap_q <= live;
        if (wrap) overflow_o <= 1'b1;
      end
    end
  end

  bcd_counter_chain #(
    .DIGITS (DIGITS)
  ) u_chain (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_valid),
    .tick_i   (tick),
    .digits_o (live),
    .wrap_o   (wrap)
  );

  // Outputs are registered from the current index so all three move together
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_o   <= ~DIGITS'(1);
      seg_o  <= SEG_TABLE[0];
      dp_o   <= (DP_POS != 0);
    end else begin
      if (scan_q == SCAN_LIM) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      an_o  <= ~(DIGITS'(1) << idx_q);
      seg_o <= seg_of(disp[idx_q]);
      dp_o  <= (idx_q != IDX_W'(DP_POS));
    end
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch at 10 clk/tick and 4 clk/scan step;
// a second 2-digit instance exercises wrap/overflow in a short run.
module tb_lap_stopwatch;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lap_stopwatch_if #(.DIGITS(4)) sw ();
  lap_stopwatch_if #(.DIGITS(2)) sw2 ();

  lap_stopwatch #(
    .CLK_FREQ (1000), .TICK_FREQ (100), .SCAN_FREQ (250), .DIGITS (4), .DP_POS (2)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n),
    .start_stop_i (sw.start_stop), .lap_i (sw.lap), .clear_i (sw.clear),
    .an_o (sw.an), .seg_o (sw.seg), .dp_o (sw.dp),
    .running_o (sw.running), .lap_active_o (sw.lap_active), .overflow_o (sw.overflow)
  );

  lap_stopwatch #(
    .CLK_FREQ (1000), .TICK_FREQ (100), .SCAN_FREQ (250), .DIGITS (2), .DP_POS (0)
  ) dut2 (
    .clk_i (clk), .rst_ni (rst_n),
    .start_stop_i (sw2.start_stop), .lap_i (sw2.lap), .clear_i (sw2.clear),
    .an_o (sw2.an), .seg_o (sw2.seg), .dp_o (sw2.dp),
    .running_o (sw2.running), .lap_active_o (sw2.lap_active), .overflow_o (sw2.overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic s, input logic l, input logic c);
    sw.start_stop = s; sw.lap = l; sw.clear = c;
    cyc(1);
    sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clear = 1'b0;
  endtask

  task automatic strobe2(input logic s, input logic c);
    sw2.start_stop = s; sw2.clear = c;
    cyc(1);
    sw2.start_stop = 1'b0; sw2.clear = 1'b0;
  endtask

  function automatic logic [3:0] seg2dig(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      default:    return 4'hF;
    endcase
  endfunction

  // Collect one full scan frame (16 cycles) from the pins into a BCD word
  task automatic read_display(output logic [15:0] val);
    val = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      for (int d = 0; d < 4; d++)
        if (sw.an[d] == 1'b0) val[d*4 +: 4] = seg2dig(sw.seg);
    end
  endtask

  initial begin
    logic [15:0] shown;
    logic [3:0]  prev_an;
    int          s;
    bit          found;

    sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clear = 1'b0;
    sw2.start_stop = 1'b0; sw2.lap = 1'b0; sw2.clear = 1'b0;

    // Reset state
    cyc(3);
    check("rst_an", 32'(sw.an), 32'h0000000E);
    check("rst_seg", 32'(sw.seg), 32'h00000040);
    check("rst_dp", 32'(sw.dp), 32'd1);
    check("rst_running", 32'(sw.running), 32'd0);
    check("rst_lap_active", 32'(sw.lap_active), 32'd0);
    check("rst_overflow", 32'(sw.overflow), 32'd0);
    check("rst_dp0", 32'(sw2.dp), 32'd0);
    check("rst_an2", 32'(sw2.an), 32'h00000002);
    rst_n = 1'b1;

    // Start and count 25 ticks
    strobe(1'b1, 1'b0, 1'b0);
    cyc(250);
    check("run_0025", 32'(dut.live), 32'h0025);
    check("run_running", 32'(sw.running), 32'd1);

    // Stop at 0037 with prescaler 6, resume loses no partial tick
    cyc(125);
    strobe(1'b1, 1'b0, 1'b0);
    check("stop_0037", 32'(dut.live), 32'h0037);
    check("stop_pre", 32'(dut.pre_q), 32'd6);
    check("stop_running", 32'(sw.running), 32'd0);
    cyc(100);
    check("hold_0037", 32'(dut.live), 32'h0037);
    check("hold_pre", 32'(dut.pre_q), 32'd6);
    strobe(1'b1, 1'b0, 1'b0);
    cyc(3);
    check("resume_3cyc", 32'(dut.live), 32'h0037);
    cyc(1);
    check("resume_4cyc", 32'(dut.live), 32'h0038);
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1);
    check("clear_live", 32'(dut.live), 32'h0000);
    check("clear_pre", 32'(dut.pre_q), 32'd0);

    // Lap freeze at 0012 while live count advances
    strobe(1'b1, 1'b0, 1'b0);
    cyc(120);
    check("lap_pre_0012", 32'(dut.live), 32'h0012);
    strobe(1'b0, 1'b1, 1'b0);
    check("lap_active", 32'(sw.lap_active), 32'd1);
    check("lap_running", 32'(sw.running), 32'd1);
    cyc(300);
    check("lap_live_0042", 32'(dut.live), 32'h0042);
    read_display(shown);
    check("lap_display", 32'(shown), 32'h0012);
    strobe(1'b0, 1'b1, 1'b0);
    check("unlap_active", 32'(sw.lap_active), 32'd0);
    strobe(1'b1, 1'b0, 1'b0);
    read_display(shown);
    check("live_display", 32'(shown), 32'h0043);

    // Clear beats start_stop in STOP; clear ignored in RUN
    strobe(1'b1, 1'b0, 1'b1);
    check("prio_clear_live", 32'(dut.live), 32'h0000);
    check("prio_clear_stop", 32'(sw.running), 32'd0);
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1);
    check("clear_in_run", 32'(sw.running), 32'd1);
    cyc(8);
    check("clear_in_run_9", 32'(dut.live), 32'h0000);
    cyc(1);
    check("clear_in_run_10", 32'(dut.live), 32'h0001);

    // start_stop beats lap in RUN; LAP_STOP paths
    strobe(1'b1, 1'b1, 1'b0);
    check("prio_ss_stop", 32'(sw.running), 32'd0);
    check("prio_ss_nolap", 32'(sw.lap_active), 32'd0);
    strobe(1'b0, 1'b1, 1'b0);
    check("lap_in_stop", 32'(sw.lap_active), 32'd0);
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    check("lapstop_run", 32'(sw.running), 32'd0);
    check("lapstop_lap", 32'(sw.lap_active), 32'd1);
    strobe(1'b0, 1'b1, 1'b0);
    check("lapstop_to_stop", 32'(sw.lap_active), 32'd0);
    strobe(1'b0, 1'b0, 1'b1);
    check("clear_after_lap", 32'(dut.live), 32'h0000);

    // Scan sequence and decimal point
    prev_an = sw.an;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(1);
      if (sw.an != prev_an) found = 1'b1;
    end
    check("scan_step_seen", 32'(found), 32'd1);
    s = 0;
    for (int d = 0; d < 4; d++) if (sw.an[d] == 1'b0) s = d;
    for (int k = 0; k < 16; k++) begin
      check("scan_an", 32'(sw.an), 32'(~(4'b0001 << ((s + k / 4) % 4)) & 4'hF));
      check("scan_dp", 32'(sw.dp), (((s + k / 4) % 4) == 2) ? 32'd0 : 32'd1);
      cyc(1);
    end

    // Two-digit wrap sets sticky overflow, clear removes it
    strobe2(1'b1, 1'b0);
    cyc(980);
    check("ovf_98", 32'(dut2.live), 32'h98);
    check("ovf_before", 32'(sw2.overflow), 32'd0);
    cyc(20);
    check("ovf_wrap_00", 32'(dut2.live), 32'h00);
    check("ovf_set", 32'(sw2.overflow), 32'd1);
    check("ovf_running", 32'(sw2.running), 32'd1);
    cyc(100);
    check("ovf_sticky", 32'(sw2.overflow), 32'd1);
    check("ovf_live_10", 32'(dut2.live), 32'h10);
    strobe2(1'b1, 1'b0);
    strobe2(1'b0, 1'b1);
    check("ovf_cleared", 32'(sw2.overflow), 32'd0);
    check("ovf_clear_live", 32'(dut2.live), 32'h00);

    // Reset wins over strobes mid-count
    strobe(1'b1, 1'b0, 1'b0);
    cyc(50);
    rst_n = 1'b0;
    sw.start_stop = 1'b1; sw.lap = 1'b1;
    cyc(1);
    check("rstprio_running", 32'(sw.running), 32'd0);
    check("rstprio_lap", 32'(sw.lap_active), 32'd0);
    check("rstprio_live", 32'(dut.live), 32'h0000);
    check("rstprio_an", 32'(sw.an), 32'h0000000E);
    rst_n = 1'b1;
    sw.start_stop = 1'b0; sw.lap = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
